// File: rtl/bsnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bsnn_pkg
//  Description : Shared types, constants and helpers for the BSNN output path.
//  Revision    : 1.0 - initial release
// ============================================================================
package bsnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } ttd_argmin_state_t;

    // Spike-time code meaning "this neuron never fired".
    localparam int unsigned TCODE_NONE = 0;

    // Index width for n classes; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ttd_argmin_if.sv
`default_nettype none
// ============================================================================
//  Module      : ttd_argmin_if
//  Description : Class-result valid/ready channel from the argmin stage to host.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ttd_argmin_if
    import bsnn_pkg::*;
#(
    parameter int TTD_WIDTH = 5,
    parameter int N_NEURONS = 4,
    parameter int CLASS_W   = clog2_min1(N_NEURONS)
);

    logic                 class_valid;
    logic                 class_ready;
    logic [CLASS_W-1:0]   class_idx;
    logic [TTD_WIDTH:0]   class_time;
    logic                 no_spike;

    modport master (
        output class_valid,
        output class_idx,
        output class_time,
        output no_spike,
        input  class_ready
    );

    modport slave (
        input  class_valid,
        input  class_idx,
        input  class_time,
        input  no_spike,
        output class_ready
    );

endinterface
`default_nettype wire

// File: rtl/ttd_argmin.sv
`default_nettype none
// ============================================================================
//  Module      : ttd_argmin
//  Description : Winner-take-all readout: snapshots decoder spike times on the
//                finish rising edge and serially finds the earliest spiker.
//  Revision    : 1.0 - initial release
// ============================================================================
module ttd_argmin
    import bsnn_pkg::*;
#(
    parameter int TTD_WIDTH = 5,
    parameter int N_NEURONS = 4
) (
    input  wire logic                                   CLK,
    input  wire logic                                   nRES,
    input  wire logic                                   ttd_finish,
    input  wire logic [N_NEURONS*(TTD_WIDTH+1)-1:0]     ttd_times,
    output logic                                        busy,
    output logic                                        overrun,
    ttd_argmin_if.master                                cls
);

    localparam int                 c_tw       = TTD_WIDTH + 1;
    localparam int                 c_class_w  = clog2_min1(N_NEURONS);
    localparam logic [c_class_w-1:0] c_last_idx = c_class_w'(N_NEURONS - 1);
    localparam logic [c_tw-1:0]    c_none     = c_tw'(TCODE_NONE);

    ttd_argmin_state_t      state_q;
    logic                   fin_q;
    logic [c_tw-1:0]        snap_q [N_NEURONS];
    logic [c_class_w-1:0]   idx_q;
    logic [c_class_w-1:0]   best_idx_q;
    logic [c_tw-1:0]        best_time_q;
    logic                   found_q;

    logic                   class_valid_q;
    logic [c_class_w-1:0]   class_idx_q;
    logic [c_tw-1:0]        class_time_q;
    logic                   no_spike_q;
    logic                   busy_q;
    logic                   overrun_q;

    logic                   w_trig;
    logic [c_tw-1:0]        w_entry;
    logic                   w_lt;
    logic                   w_win;
    logic [c_class_w-1:0]   best_idx_d;
    logic [c_tw-1:0]        best_time_d;
    logic                   found_d;

    assign w_trig = ttd_finish & ~fin_q;

    // One shared comparator; strict less-than keeps ties on the lower index.
    always_comb begin
        w_entry     = snap_q[idx_q];
        w_lt        = (w_entry < best_time_q);
        w_win       = (w_entry != c_none) && (!found_q || w_lt);
        best_idx_d  = w_win ? idx_q   : best_idx_q;
        best_time_d = w_win ? w_entry : best_time_q;
        found_d     = found_q | w_win;
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state_q       <= IDLE;
            fin_q         <= 1'b1;
            idx_q         <= '0;
            best_idx_q    <= '0;
            best_time_q   <= '0;
            found_q       <= 1'b0;
            class_valid_q <= 1'b0;
            class_idx_q   <= '0;
            class_time_q  <= '0;
            no_spike_q    <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            fin_q     <= ttd_finish;
            overrun_q <= w_trig && (state_q != IDLE);

            case (state_q)
                IDLE: begin
                    if (w_trig) begin
                        for (int i = 0; i < N_NEURONS; i++) begin
                            snap_q[i] <= ttd_times[i*c_tw +: c_tw];
                        end
                        idx_q       <= '0;
                        best_idx_q  <= '0;
                        best_time_q <= '0;
                        found_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= SCAN;
                    end
                end

                SCAN: begin
                    best_idx_q  <= best_idx_d;
                    best_time_q <= best_time_d;
                    found_q     <= found_d;
                    if (idx_q == c_last_idx) begin
                        // Result registers load from the post-compare values so
                        // the last neuron is included without an extra cycle.
                        class_valid_q <= 1'b1;
                        class_idx_q   <= best_idx_d;
                        class_time_q  <= best_time_d;
                        no_spike_q    <= ~found_d;
                        state_q       <= OUT;
                    end else begin
                        idx_q <= idx_q + c_class_w'(1);
                    end
                end

                OUT: begin
                    if (cls.class_ready) begin
                        class_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cls.class_valid = class_valid_q;
    assign cls.class_idx   = class_idx_q;
    assign cls.class_time  = class_time_q;
    assign cls.no_spike    = no_spike_q;
    assign busy            = busy_q;
    assign overrun         = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ttd_argmin.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ttd_argmin
//  Description : Directed, table-driven self-checking bench for ttd_argmin.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ttd_argmin;

    localparam int TW = 6;
    localparam int NN = 4;

    logic              clk;
    logic              nres;
    logic              ttd_finish;
    logic [NN*TW-1:0]  ttd_times;
    logic              busy;
    logic              overrun;

    int n_vec;
    int n_err;
    int ov_cnt;

    ttd_argmin_if #(.TTD_WIDTH(5), .N_NEURONS(4)) cif ();

    ttd_argmin #(.TTD_WIDTH(5), .N_NEURONS(4)) dut (
        .CLK        (clk),
        .nRES       (nres),
        .ttd_finish (ttd_finish),
        .ttd_times  (ttd_times),
        .busy       (busy),
        .overrun    (overrun),
        .cls        (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] t0, t1, t2, t3;
        logic [1:0] idx;
        logic [5:0] tm;
        logic       ns;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (overrun === 1'b1) ov_cnt++;
    endtask

    function automatic logic [NN*TW-1:0] pack(input logic [5:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Leaves time at 1 unit after edge E (snapshot edge).
    task automatic arm(input logic [NN*TW-1:0] t);
        ttd_times  = t;
        ttd_finish = 1'b0;
        tick();
        ttd_finish = 1'b1;
        tick();
    endtask

    task automatic chk_result(input string tag, input logic [1:0] idx, input logic [5:0] tm, input logic ns);
        chk({tag, " valid"},    32'(cif.class_valid), 32'd1);
        chk({tag, " idx"},      32'(cif.class_idx),   32'(idx));
        chk({tag, " time"},     32'(cif.class_time),  32'(tm));
        chk({tag, " no_spike"}, 32'(cif.no_spike),    32'(ns));
        chk({tag, " busy"},     32'(busy),            32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; ov_cnt = 0;

        tbl[0] = '{t0:6'd9,  t1:6'd3,  t2:6'd7,  t3:6'd5,  idx:2'd1, tm:6'd3,  ns:1'b0};
        tbl[1] = '{t0:6'd0,  t1:6'd6,  t2:6'd0,  t3:6'd6,  idx:2'd1, tm:6'd6,  ns:1'b0};
        tbl[2] = '{t0:6'd0,  t1:6'd0,  t2:6'd0,  t3:6'd0,  idx:2'd0, tm:6'd0,  ns:1'b1};
        tbl[3] = '{t0:6'd63, t1:6'd62, t2:6'd0,  t3:6'd1,  idx:2'd3, tm:6'd1,  ns:1'b0};
        tbl[4] = '{t0:6'd5,  t1:6'd5,  t2:6'd5,  t3:6'd5,  idx:2'd0, tm:6'd5,  ns:1'b0};
        tbl[5] = '{t0:6'd0,  t1:6'd0,  t2:6'd0,  t3:6'd20, idx:2'd3, tm:6'd20, ns:1'b0};
        tbl[6] = '{t0:6'd2,  t1:6'd0,  t2:6'd1,  t3:6'd0,  idx:2'd2, tm:6'd1,  ns:1'b0};
        tbl[7] = '{t0:6'd1,  t1:6'd63, t2:6'd63, t3:6'd63, idx:2'd0, tm:6'd1,  ns:1'b0};

        // Reset with finish held high, as the decoder does out of reset.
        nres = 1'b0; ttd_finish = 1'b1; ttd_times = '0; cif.class_ready = 1'b0;
        #23;
        chk("rst valid",    32'(cif.class_valid), 32'd0);
        chk("rst idx",      32'(cif.class_idx),   32'd0);
        chk("rst time",     32'(cif.class_time),  32'd0);
        chk("rst no_spike", 32'(cif.no_spike),    32'd0);
        chk("rst busy",     32'(busy),            32'd0);
        chk("rst overrun",  32'(overrun),         32'd0);
        tick();
        nres = 1'b1;
        ttd_times = pack(6'd1, 6'd2, 6'd3, 6'd4);
        for (int i = 0; i < 8; i++) tick();
        chk("post-release busy",  32'(busy),            32'd0);
        chk("post-release valid", 32'(cif.class_valid), 32'd0);

        // Table: ready held high in advance, one transfer per vector.
        cif.class_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            arm(pack(tbl[v].t0, tbl[v].t1, tbl[v].t2, tbl[v].t3));
            chk($sformatf("v%0d busy@E", v), 32'(busy), 32'd1);
            tick(); tick(); tick();
            chk($sformatf("v%0d early valid", v), 32'(cif.class_valid), 32'd0);
            tick();
            chk_result($sformatf("v%0d", v), tbl[v].idx, tbl[v].tm, tbl[v].ns);
            tick();
            chk($sformatf("v%0d post valid", v), 32'(cif.class_valid), 32'd0);
            chk($sformatf("v%0d post busy", v),  32'(busy),            32'd0);
        end

        // Backpressure with snapshot isolation: inputs change mid-scan.
        cif.class_ready = 1'b0;
        arm(pack(6'd9, 6'd3, 6'd7, 6'd5));
        tick();
        ttd_times = pack(6'd1, 6'd1, 6'd1, 6'd1);
        tick(); tick(); tick();
        for (int c = 0; c < 10; c++) begin
            chk_result($sformatf("bp c%0d", c), 2'd1, 6'd3, 1'b0);
            tick();
        end
        chk_result("bp final", 2'd1, 6'd3, 1'b0);
        cif.class_ready = 1'b1;
        tick();
        chk("bp xfer valid", 32'(cif.class_valid), 32'd0);
        chk("bp xfer busy",  32'(busy),            32'd0);

        // Overrun: one extra finish pulse during SCAN, another during OUT.
        cif.class_ready = 1'b0;
        ov_cnt = 0;
        arm(pack(6'd4, 6'd8, 6'd2, 6'd6));
        ttd_finish = 1'b0;
        tick();
        ttd_finish = 1'b1;
        tick();
        chk("ovr scan pulse", 32'(overrun), 32'd1);
        tick(); tick();
        chk_result("ovr first", 2'd2, 6'd2, 1'b0);
        ttd_finish = 1'b0;
        tick();
        ttd_finish = 1'b1;
        tick();
        chk("ovr out pulse", 32'(overrun), 32'd1);
        tick();
        chk("ovr pulse width", 32'(overrun), 32'd0);
        chk_result("ovr held", 2'd2, 6'd2, 1'b0);
        cif.class_ready = 1'b1;
        tick();
        chk("ovr xfer valid", 32'(cif.class_valid), 32'd0);
        for (int c = 0; c < 10; c++) tick();
        chk("ovr no second result", 32'(cif.class_valid), 32'd0);
        chk("ovr busy idle",        32'(busy),            32'd0);
        chk("ovr pulse count",      32'(ov_cnt),          32'd2);

        // Asynchronous reset two edges into a scan.
        arm(pack(6'd9, 6'd3, 6'd7, 6'd5));
        tick(); tick();
        chk("ar busy before", 32'(busy), 32'd1);
        #2;
        nres = 1'b0;
        #1;
        chk("ar busy",  32'(busy),            32'd0);
        chk("ar valid", 32'(cif.class_valid), 32'd0);
        chk("ar idx",   32'(cif.class_idx),   32'd0);
        chk("ar time",  32'(cif.class_time),  32'd0);
        tick();
        nres = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        chk("ar release idle", 32'(busy), 32'd0);
        arm(pack(6'd0, 6'd0, 6'd8, 6'd0));
        tick(); tick(); tick();
        chk("ar2 early valid", 32'(cif.class_valid), 32'd0);
        tick();
        chk_result("ar2", 2'd2, 6'd8, 1'b0);
        tick();
        chk("ar2 post valid", 32'(cif.class_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
